// File: rtl/imem_stage.sv
// imem_stage: RV32I memory-access stage; drives a req/ack data bus, aligns load data, registers MEM/WB.
// Optional MISALIGN_TRAP_EN: misaligned accesses become bubbles with a one-cycle o_imem_misaligned flag.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef RF_ADD_SIZE
`define RF_ADD_SIZE 5
`endif
module imem_stage #(
    parameter int WIDTH       = `WIDTH,
    parameter int RF_ADD_SIZE = `RF_ADD_SIZE
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_imem_valid,
    input  logic [WIDTH-1:0]       i_imem_alu_out,
    input  logic [WIDTH-1:0]       i_imem_store_data,
    input  logic                   i_imem_mem_re,
    input  logic                   i_imem_mem_we,
    input  logic [2:0]             i_imem_funct3,
    input  logic                   i_imem_rf_we_ctrl,
    input  logic [2:0]             i_imem_rf_wb_src_ctrl,
    input  logic [WIDTH-1:0]       i_imem_sx_data,
    input  logic [WIDTH-1:0]       i_imem_pc_plus_4,
    input  logic [WIDTH-1:0]       i_imem_bu_next_dest_jb,
    input  logic [RF_ADD_SIZE-1:0] i_imem_dst,
    output logic                   o_imem_stall,
    output logic                   o_dmem_req,
    output logic                   o_dmem_we,
    output logic [WIDTH-1:0]       o_dmem_addr,
    output logic [WIDTH-1:0]       o_dmem_wdata,
    output logic [3:0]             o_dmem_be,
    input  logic                   i_dmem_ack,
    input  logic [WIDTH-1:0]       i_dmem_rdata,
    output logic [WIDTH-1:0]       o_iwb_alu_out,
    output logic [WIDTH-1:0]       o_iwb_r_mem,
    output logic [WIDTH-1:0]       o_iwb_sx_data,
    output logic [WIDTH-1:0]       o_iwb_pc_plus_4,
    output logic [WIDTH-1:0]       o_iwb_bu_next_dest_jb,
    output logic                   o_iwb_rf_we_ctrl,
    output logic [2:0]             o_iwb_rf_wb_src_ctrl,
    output logic [RF_ADD_SIZE-1:0] o_iwb_dst,
    output logic                   o_imem_misaligned
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0] be_q, be_d;
    logic we_q, we_d;
    logic [2:0] f3_q, f3_d;
    logic [1:0] off_q, off_d, off;
    logic [WIDTH-1:0] alu_q, alu_d, rmem_q, rmem_d, sx_q, sx_d, pc4_q, pc4_d, jb_q, jb_d;
    logic rfwe_q, rfwe_d;
    logic [2:0] src_q, src_d;
    logic [RF_ADD_SIZE-1:0] dst_q, dst_d;
    logic memop, is_word, is_half, mis, go, trap, stall, bubble;
    logic [7:0] ld_b;
    logic [15:0] ld_h;
    logic [WIDTH-1:0] ld_ext;
    assign memop   = i_imem_valid & (i_imem_mem_re | i_imem_mem_we);
    assign is_word = i_imem_funct3[1];
    assign is_half = i_imem_funct3[1:0] == 2'b01;
    assign mis     = is_word ? |i_imem_alu_out[1:0] : is_half & i_imem_alu_out[0];
    assign off     = mis ? 2'b00 : i_imem_alu_out[1:0];
`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    assign go   = memop & ~mis;
    assign trap = memop & mis;
    assign o_imem_misaligned = mis_q;
`else
    assign go   = memop;
    assign trap = 1'b0;
    assign o_imem_misaligned = 1'b0;
`endif
    // Latched offset already has misaligned low bits forced to zero
    assign ld_b   = i_dmem_rdata[{off_q, 3'b000} +: 8];
    assign ld_h   = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];
    assign ld_ext = f3_q[1] ? i_dmem_rdata
                  : f3_q[0] ? {{(WIDTH-16){~f3_q[2] & ld_h[15]}}, ld_h}
                  : {{(WIDTH-8){~f3_q[2] & ld_b[7]}}, ld_b};
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        stall   = 1'b0;
        if (state_q == IDLE) begin
            stall = go;
            if (go) begin
                state_d = BUSY;
                addr_d  = {i_imem_alu_out[WIDTH-1:2], 2'b00};
                wdata_d = is_word ? i_imem_store_data
                        : is_half ? {(WIDTH/16){i_imem_store_data[15:0]}}
                        : {(WIDTH/8){i_imem_store_data[7:0]}};
                be_d    = is_word ? 4'b1111 : is_half ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
                we_d    = i_imem_mem_we;
                f3_d    = i_imem_funct3;
                off_d   = off;
            end
        end else begin
            stall = ~i_dmem_ack;
            if (i_dmem_ack) state_d = IDLE;
        end
        bubble = stall | (state_q == IDLE & trap);
        alu_d  = bubble ? '0 : i_imem_alu_out;
        sx_d   = bubble ? '0 : i_imem_sx_data;
        pc4_d  = bubble ? '0 : i_imem_pc_plus_4;
        jb_d   = bubble ? '0 : i_imem_bu_next_dest_jb;
        src_d  = bubble ? '0 : i_imem_rf_wb_src_ctrl;
        dst_d  = bubble ? '0 : i_imem_dst;
        rfwe_d = ~bubble & i_imem_rf_we_ctrl & i_imem_valid;
        rmem_d = (state_q == BUSY & ~stall & ~we_q) ? ld_ext : '0;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            alu_q   <= '0;
            rmem_q  <= '0;
            sx_q    <= '0;
            pc4_q   <= '0;
            jb_q    <= '0;
            rfwe_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            alu_q   <= alu_d;
            rmem_q  <= rmem_d;
            sx_q    <= sx_d;
            pc4_q   <= pc4_d;
            jb_q    <= jb_d;
            rfwe_q  <= rfwe_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= state_q == IDLE & trap;
`endif
        end
    end
    // Stall is gated by reset so upstream is released the moment reset asserts
    assign o_imem_stall          = i_rstn & stall;
    assign o_dmem_req            = state_q == BUSY;
    assign o_dmem_we             = we_q;
    assign o_dmem_addr           = addr_q;
    assign o_dmem_wdata          = wdata_q;
    assign o_dmem_be             = be_q;
    assign o_iwb_alu_out         = alu_q;
    assign o_iwb_r_mem           = rmem_q;
    assign o_iwb_sx_data         = sx_q;
    assign o_iwb_pc_plus_4       = pc4_q;
    assign o_iwb_bu_next_dest_jb = jb_q;
    assign o_iwb_rf_we_ctrl      = rfwe_q;
    assign o_iwb_rf_wb_src_ctrl  = src_q;
    assign o_iwb_dst             = dst_q;
endmodule

// File: doc/imem_stage.md
# imem_stage

Memory-access stage of the pipelined RV32I core, between execute and writeback. Takes the EX/MEM bundle, runs a load or store on the data-memory bus with a req/ack handshake, and aligns and extends load data. It stalls upstream until the access completes and registers the result into the MEM/WB register that drives `iwb_stage`.

## Interface
- `WIDTH`, default `` `WIDTH `` (32): datapath width.
- `RF_ADD_SIZE`, default `` `RF_ADD_SIZE `` (5): register-file address width.
- `i_clk` in 1: clock, rising edge.
- `i_rstn` in 1: reset. Asynchronous, active-low.
- `i_imem_valid` in 1: the EX/MEM bundle holds a real instruction.
- `i_imem_alu_out` in WIDTH: ALU result; this is the address for loads and stores.
- `i_imem_store_data` in WIDTH: rs2 value for stores.
- `i_imem_mem_re`, `i_imem_mem_we` in 1 each: load and store request.
- `i_imem_funct3` in 3: access size and sign (RV32I encoding).
- `i_imem_rf_we_ctrl` in 1: register-file write enable, passed through.
- `i_imem_rf_wb_src_ctrl` in 3: writeback source select, passed through.
- `i_imem_sx_data`, `i_imem_pc_plus_4`, `i_imem_bu_next_dest_jb` in WIDTH each: passed through.
- `i_imem_dst` in RF_ADD_SIZE: destination register.
- `o_imem_stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `o_dmem_req` out 1: bus request.
- `o_dmem_we` out 1: bus write.
- `o_dmem_addr` out WIDTH: bus address, word-aligned.
- `o_dmem_wdata` out WIDTH: write data, replicated per lane.
- `o_dmem_be` out 4: byte enables.
- `i_dmem_ack` in 1: bus acknowledge.
- `i_dmem_rdata` in WIDTH: read data.
- `o_iwb_alu_out`, `o_iwb_r_mem`, `o_iwb_sx_data`, `o_iwb_pc_plus_4`, `o_iwb_bu_next_dest_jb` out WIDTH each: MEM/WB register.
- `o_iwb_rf_we_ctrl` out 1, `o_iwb_rf_wb_src_ctrl` out 3, `o_iwb_dst` out RF_ADD_SIZE: MEM/WB register.
- `o_imem_misaligned` out 1: registered one-cycle flag for a misaligned access.

## Operation
- **Definitions**
  - memop = `i_imem_valid & (mem_re | mem_we)`.
  - If both `mem_re` and `mem_we` are set, the access is a store.
- **Alignment**
  - Halfword access needs addr[0]=0.
  - Word access needs addr[1:0]=0.
  - funct3 011, 110 and 111 are treated as a word access.
- **FSM state IDLE**
  - On an aligned memop: `o_imem_stall`=1; next edge latches addr/wdata/be/we/funct3/addr[1:0] into request registers and moves to BUSY.
  - On a non-memop: the MEM/WB register loads the bundle at the edge. `o_iwb_rf_we_ctrl` = `rf_we_ctrl & i_imem_valid`.
  - `i_dmem_ack` is ignored in IDLE.
- **FSM state BUSY**
  - `o_dmem_req`=1; request outputs are held stable.
  - `o_imem_stall` = `~i_dmem_ack`.
  - On the edge with ack=1: the MEM/WB register loads the bundle plus the extracted load data, and the FSM returns to IDLE.
- **Bubbles:** every cycle where `o_imem_stall`=1 loads a bubble into MEM/WB. A bubble sets `rf_we`=0 and clears all other fields to 0.
- **Store lanes**
  - SB: be = 0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<{addr[1],0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
- **Load extract:** d = rdata >> 8·addr[1:0].
  - LB / LBU: sign- or zero-extend d[7:0].
  - LH / LHU: sign- or zero-extend d[15:0].
  - LW: rdata unchanged.
- **Bus address:** `o_dmem_addr` = {addr[WIDTH-1:2], 2'b00}.
- **Non-load instructions:** `o_iwb_r_mem` = 0.

## Timing
- Reset (asynchronous): FSM goes to IDLE; every output register is 0, including `o_dmem_req`, `o_dmem_be`, `o_imem_misaligned` and all `o_iwb_*`.
- `o_imem_stall` is combinational: `(IDLE & aligned memop) | (BUSY & ~ack)`.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: 2+N cycles, where N is the number of BUSY cycles before ack. A zero-wait bus gives 2.
- Handshake: `o_dmem_req` is asserted only in BUSY and drops the cycle after ack. Back-to-back memops therefore have one idle bus cycle between them.
- Reset mid-access: the bus request drops asynchronously and the access is abandoned. The bus must tolerate this.

## Configuration
- Macro: `MISALIGN_TRAP_EN`.
- **Defined**
  - A misaligned memop issues no bus request and does not stall.
  - MEM/WB loads a bubble, and `o_imem_misaligned`=1 for one cycle.
- **Undefined**
  - The misaligned memop proceeds with addr[1:0] forced to 00 for lane and extract logic.
  - `o_imem_misaligned` is tied to 0.

## Test plan
- LW, addr 0x100, ack on the first BUSY cycle, rdata 0xDEADBEEF:
  - stall is high for exactly 1 cycle;
  - `o_iwb_r_mem`=0xDEADBEEF two edges after presentation.
- LB, addr 0x103, rdata 0x80112233 → `o_iwb_r_mem`=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH, addr 0x102, rs2 0x0000ABCD, ack after 3 wait cycles:
  - be=1100, wdata=0xABCDABCD, addr 0x100;
  - req is held for 4 cycles;
  - stall is high for 4 cycles;
  - `o_iwb_rf_we_ctrl`=0.
- ADD result 0x5 to x7 with no memop → `o_iwb_alu_out`=5, `o_iwb_dst`=7 after 1 edge, with no stall and no req.
- LW at 0x101:
  - with `MISALIGN_TRAP_EN` defined: no req, `o_imem_misaligned` pulses, bubble in WB;
  - with it undefined: a word read at 0x100.
- `i_rstn` low during BUSY → req, stall and all `o_iwb_*` go to 0 immediately; the FSM is in IDLE after release.
